// File: rtl/shift_load_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : shift_load_ctrl                                              |
// | Description : Loads a parallel word into a chain of load/enable shift      |
// |               cells, shifts it out over WIDTH enabled cycles, and          |
// |               recaptures the outgoing bits (LSB first) into cap_data.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module shift_load_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_fill,
  input  logic             stall,
  input  logic             ser_q,
  output logic [WIDTH-1:0] R,
  output logic             L,
  output logic             E,
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cap_data
);

  // Counter is wide enough to hold WIDTH itself, so it never wraps.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             w_q, w_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shift_en;

  // Cell controls are decoded straight from the registered state so the
  // cells see them in the same cycle; ready is also masked while in reset.
  always_comb begin
    in_ready = 1'b0;
    L        = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready = ~reset;
      ST_LOAD:  begin L = 1'b1; busy = 1'b1; end
      ST_SHIFT: begin shift_en = ~stall; busy = 1'b1; end
      ST_DONE:  begin done = 1'b1; busy = 1'b1; end
      default:  in_ready = 1'b0;
    endcase
  end

  // Next-state, word/fill capture on accept, and shift-side recapture.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    w_d     = w_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          r_d     = in_data;
          w_d     = in_fill;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shift_en) begin
          // The bit leaving cell 0 enters at the top so the word lands in order.
          cap_d = {ser_q, cap_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      w_q     <= 1'b0;
      cap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      w_q     <= w_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign E        = shift_en;
  assign R        = r_q;
  assign w        = w_q;
  assign cap_data = cap_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_load_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_shift_load_ctrl                                           |
// | Description : Self-checking bench for shift_load_ctrl with a cell chain    |
// |               model attached to R/L/E/w/ser_q.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_shift_load_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_fill;
  logic         stall;
  logic         ser_q;
  logic [W-1:0] R;
  logic         L;
  logic         E;
  logic         w;
  logic         busy;
  logic         done;
  logic [W-1:0] cap_data;

  logic [W-1:0] cells = '0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  shift_load_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_fill  (in_fill),
    .stall    (stall),
    .ser_q    (ser_q),
    .R        (R),
    .L        (L),
    .E        (E),
    .w        (w),
    .busy     (busy),
    .done     (done),
    .cap_data (cap_data)
  );

  // Chain of W cells: w enters cell W-1, cell 0 is the one leaving.
  always @(posedge clk) begin
    if (L)      cells <= R;
    else if (E) cells <= {w, cells[W-1:1]};
  end
  assign ser_q = cells[0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // One cycle of inputs with expected outputs; ctl = {in_ready,L,E,busy,done}.
  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         s;
    logic [4:0]   ctl;
    logic [W-1:0] cap;
    logic [W-1:0] r;
    logic [W-1:0] cl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [W-1:0] d, input logic s,
                              input logic [4:0] ctl, input logic [W-1:0] cap,
                              input logic [W-1:0] r, input logic [W-1:0] cl);
    vec_t t;
    t.v = v; t.d = d; t.s = s; t.ctl = ctl; t.cap = cap; t.r = r; t.cl = cl;
    tbl.push_back(t);
  endfunction

  task automatic run_frame(input logic [W-1:0] d, input logic f,
                           output logic [W-1:0] cap, output bit got);
    got = 0; cap = '0;
    in_valid = 1'b1; in_data = d; in_fill = f; stall = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done) begin got = 1; cap = cap_data; end
      @(posedge clk); #1;
    end
  endtask

  initial begin : main
    int           n_e;
    bit           saw_done;
    bit           got;
    logic [W-1:0] fcap;
    int           acc[$];
    int           dn[$];
    logic [W-1:0] caps[$];
    logic [W-1:0] r_at_done;
    bit           m_act;
    int           m_age;
    int           m_sh;
    logic [W-1:0] m_word;
    logic         m_fill;
    logic [4:0]   exp_ctl;

    // ---------------- reset ----------------
    reset = 1'b1; in_valid = 1'b1; in_data = 4'b1111; in_fill = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_ctl", {in_ready, L, E, busy, done}, 5'b00000);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("idle_ctl", {in_ready, L, E, busy, done}, 5'b10000);
    chk("idle_R", R, 4'b0000);
    chk("idle_cap", cap_data, 4'b0000);
    chk("idle_w", w, 1'b0);
    @(posedge clk); #1;

    // ---------------- table: plain frame, then stalled frame ----------------
    add(1, 4'b1011, 0, 5'b10000, 4'b0000, 4'b0000, 4'b0000); // accept
    add(0, 4'b0000, 0, 5'b01010, 4'b0000, 4'b1011, 4'b0000); // LOAD
    add(0, 4'b0000, 0, 5'b00110, 4'b0000, 4'b1011, 4'b1011);
    add(1, 4'b0101, 0, 5'b00110, 4'b1000, 4'b1011, 4'b0101); // valid in SHIFT ignored
    add(0, 4'b0000, 0, 5'b00110, 4'b1100, 4'b1011, 4'b0010);
    add(0, 4'b0000, 0, 5'b00110, 4'b0110, 4'b1011, 4'b0001);
    add(1, 4'b0101, 0, 5'b00011, 4'b1011, 4'b1011, 4'b0000); // DONE, valid ignored
    add(0, 4'b0000, 0, 5'b10000, 4'b1011, 4'b1011, 4'b0000);
    add(1, 4'b1011, 1, 5'b10000, 4'b1011, 4'b1011, 4'b0000); // accept with stall
    add(0, 4'b0000, 1, 5'b01010, 4'b1011, 4'b1011, 4'b0000); // LOAD ignores stall
    add(0, 4'b0000, 0, 5'b00110, 4'b1011, 4'b1011, 4'b1011);
    add(0, 4'b0000, 0, 5'b00110, 4'b1101, 4'b1011, 4'b0101);
    add(0, 4'b0000, 1, 5'b00010, 4'b1110, 4'b1011, 4'b0010);
    add(0, 4'b0000, 1, 5'b00010, 4'b1110, 4'b1011, 4'b0010);
    add(0, 4'b0000, 0, 5'b00110, 4'b1110, 4'b1011, 4'b0010);
    add(0, 4'b0000, 0, 5'b00110, 4'b0111, 4'b1011, 4'b0001);
    add(0, 4'b0000, 0, 5'b00011, 4'b1011, 4'b1011, 4'b0000); // DONE at T+8
    add(0, 4'b0000, 0, 5'b10000, 4'b1011, 4'b1011, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; in_fill = 1'b0; stall = tbl[i].s;
      @(negedge clk);
      chk($sformatf("tbl%0d_ctl", i), {in_ready, L, E, busy, done}, tbl[i].ctl);
      chk($sformatf("tbl%0d_cap", i), cap_data, tbl[i].cap);
      chk($sformatf("tbl%0d_R", i), R, tbl[i].r);
      chk($sformatf("tbl%0d_cells", i), cells, tbl[i].cl);
      chk($sformatf("tbl%0d_w", i), w, 1'b0);
      @(posedge clk); #1;
    end

    // ---------------- back-to-back with in_valid held ----------------
    in_valid = 1'b1; in_data = 4'b0110; in_fill = 1'b1; stall = 1'b0;
    r_at_done = '0;
    for (int c = 0; c < 40 && dn.size() < 2; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc.push_back(c);
      if (done) begin
        dn.push_back(c);
        caps.push_back(cap_data);
        if (dn.size() == 1) r_at_done = R;
      end
      @(posedge clk); #1;
      if (acc.size() == 1) in_data = 4'b1001;
      if (dn.size() == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", acc.size(), 2);
    chk("b2b_dones", dn.size(), 2);
    if (acc.size() == 2 && dn.size() == 2) begin
      chk("b2b_latency", dn[0] - acc[0], W + 2);
      chk("b2b_gap", acc[1] - dn[0], 1);
      chk("b2b_cap0", caps[0], 4'b0110);
      chk("b2b_cap1", caps[1], 4'b1001);
      chk("b2b_R_held", r_at_done, 4'b0110);
      chk("b2b_cells", cells, 4'b1111);
    end

    // ---------------- reset mid-SHIFT ----------------
    in_valid = 1'b1; in_data = 4'b1101; in_fill = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_e = 0; saw_done = 0;
    for (int i = 0; i < 10 && n_e < 2; i++) begin
      @(negedge clk);
      if (E) n_e++;
      if (done) saw_done = 1;
      @(posedge clk); #1;
    end
    chk("mid_two_shifts", n_e, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_ready_in_reset", in_ready, 1'b0);
    if (done) saw_done = 1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_ctl", {in_ready, L, E, busy, done}, 5'b10000);
    chk("mid_R", R, 4'b0000);
    chk("mid_cap", cap_data, 4'b0000);
    chk("mid_w", w, 1'b0);
    chk("mid_no_done", saw_done, 1'b0);
    @(posedge clk); #1;
    run_frame(4'b0011, 1'b1, fcap, got);
    chk("post_rst_done", got, 1'b1);
    chk("post_rst_cap", fcap, 4'b0011);
    chk("post_rst_cells", cells, 4'b1111);

    // ---------------- randomized vs frame-timing model ----------------
    m_act = 0; m_age = 0; m_sh = 0; m_word = 4'b0011; m_fill = 1'b1;
    for (int c = 0; c < 500; c++) begin
      in_valid = ($urandom_range(0, 9) < 4);
      in_data  = W'($urandom);
      in_fill  = 1'($urandom);
      stall    = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      exp_ctl = {!m_act, m_act && m_age == 0, m_act && m_age > 0 && m_sh < W && !stall,
                 m_act, m_act && m_sh == W};
      chk($sformatf("rnd%0d_ctl", c), {in_ready, L, E, busy, done}, exp_ctl);
      chk($sformatf("rnd%0d_R", c), R, m_word);
      chk($sformatf("rnd%0d_w", c), w, m_fill);
      if (m_act && m_sh == W) begin
        chk($sformatf("rnd%0d_cap", c), cap_data, m_word);
        chk($sformatf("rnd%0d_cells", c), cells, {W{m_fill}});
      end
      @(posedge clk);
      if (!m_act) begin
        if (in_valid) begin
          m_act = 1; m_age = 0; m_sh = 0; m_word = in_data; m_fill = in_fill;
        end
      end else if (m_sh == W) begin
        m_act = 0;
      end else begin
        if (m_age > 0 && !stall) m_sh++;
        m_age++;
      end
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_load_ctrl.md
# shift_load_ctrl

Control stage that sits directly upstream of a chain of WIDTH load/enable shift cells (each cell: next = L ? R : (E ? w : Q)). It accepts a parallel word over a valid/ready handshake, drives the cells' load strobe L, shift enable E, parallel load bus R and serial fill input w, then runs WIDTH shift cycles. During those cycles it recaptures the bits leaving the last cell, so the word returned on `cap_data` is the word that left the chain.

## Interface
- WIDTH, 4, number of shift cells driven; legal range 2..32
- clk  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- in_valid  in  1  upstream word available
- in_ready  out  1  block can accept a word; high only in IDLE and while reset is low
- in_data  in  WIDTH  parallel word to load into the chain
- in_fill  in  1  serial fill bit shifted into the chain for this frame; sampled with in_data
- stall  in  1  pauses shifting while high; ignored outside SHIFT
- ser_q  in  1  Q of the last cell in the chain, i.e. the bit that leaves on the next shift
- R  out  WIDTH  parallel load value to cells, bit i drives cell i
- L  out  1  load strobe to all cells
- E  out  1  shift enable to all cells
- w  out  1  serial input to the first cell (cell WIDTH-1)
- busy  out  1  high in LOAD, SHIFT and DONE
- done  out  1  one-cycle pulse marking `cap_data` valid
- cap_data  out  WIDTH  word recaptured from `ser_q`; holds its value until the next frame's first shift

## Operation
- States: IDLE, LOAD, SHIFT, DONE. Encoding is free.
- Reset: state=IDLE, R=0, w=0, cap_data=0, shift count=0. L, E, busy and done are all 0. in_ready is 0 while reset is high.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: register R<=in_data and w<=in_fill, then go to LOAD.
  - Otherwise stay in IDLE, with R and w unchanged.
- LOAD:
  - L=1 and E=0 for exactly one cycle. The cells capture R on the edge that ends LOAD.
  - Clear the count, then go to SHIFT. stall has no effect in this state.
- SHIFT:
  - E = ~stall.
  - On each edge with E=1: cap_data <= {ser_q, cap_data[WIDTH-1:1]} and count += 1.
  - The transition to DONE happens on the edge where count reaches WIDTH.
  - With stall=1: E=0, and count and cap_data hold.
  - Count width is clog2(WIDTH+1). The count never wraps.
- DONE: done=1 for one cycle, L=0, E=0, then go to IDLE. in_valid is not accepted in DONE.
- Bits leave the chain starting from cell 0, i.e. LSB first. After WIDTH shifts, cap_data equals the word that was loaded, and every cell holds w.
- L and E are never high in the same cycle.
- R and w stay stable from the accept until the next accept.
- reset high in any state returns the block to IDLE on that edge with the reset values above. A partial frame is abandoned with no done pulse.

## Timing
- L, E, busy, done and in_ready are decoded from the registered state (plus stall for E), so the cells see them in the same cycle.
- Accept edge T: LOAD occupies cycle T+1.
- With no stall, SHIFT occupies cycles T+2 .. T+1+WIDTH, DONE is cycle T+2+WIDTH, and in_ready is high again in cycle T+3+WIDTH.
- Frame period is WIDTH+3 cycles, plus 1 cycle per stalled SHIFT cycle.
- cap_data is final in the DONE cycle.

## Test plan
- Reset, then idle: check L=E=busy=done=0, R=0, cap_data=0, and in_ready=1 from the first cycle after reset falls.
- Single frame, with WIDTH=4 and cell models attached, in_data=4'b1011, in_fill=0:
  - L is high for exactly 1 cycle, then E is high for 4 cycles.
  - done pulses in cycle T+6 with cap_data=4'b1011.
  - Cells end at 4'b0000.
  - in_ready is 0 from T+1 to T+6.
- Stall: same frame with stall high for 2 cycles mid-SHIFT. E drops during the stall, done moves to T+8, and cap_data is still 4'b1011. stall held high during LOAD has no effect.
- Back-to-back frames, with in_valid held high for 4'b0110 then 4'b1001 and in_fill=1:
  - The second word is accepted only in the cycle after DONE.
  - The cap_data values are 4'b0110 and 4'b1001.
  - Cells end at 4'b1111.
- Reset mid-SHIFT, asserted after 2 shifts: next cycle is IDLE with all outputs at reset values and no done pulse. A following frame completes correctly.
- in_valid asserted during DONE and during SHIFT is not accepted, and R does not change until in_ready=1.
